program_loader: RTL and testbench

//  Upstream boot stage of the cpu. Receives a framed byte stream and assembles 24-bit

---
 rtl/program_loader.sv | 191 +++++++++++++++++++
 tb/tb_program_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot loader: parses SYNC/N/payload/CHK frames, writes 24-bit instructions into
// instruction memory and holds the cpu in reset until a frame's checksum verifies.
module program_loader #(
    parameter int          ADDR_W    = 8,
    parameter int          INSTR_W   = 24,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int          TIMEOUT   = 1000
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_reset,
    output logic               done,
    output logic               error,
    output logic [2:0]         state_dbg
);

    // Byte stream handshake: a byte transfers on every rising edge where
    // rx_valid & rx_ready; rx_ready is held high so the source never stalls.
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int          IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
        CHECK = 3'd3,
        RUN   = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                rx_ready_q;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [INSTR_W-1:0]  wdata_q, wdata_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [7:0]          rem_q, rem_d;
    logic [7:0]          chk_q, chk_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [15:0]         asm_q, asm_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;

    logic                accept;
    logic                is_sync;
    logic                in_frame;
    logic [31:0]         n_ext;

    assign accept  = rx_valid & rx_ready_q;
    assign is_sync = (rx_data == SYNC_BYTE);
    assign n_ext   = {24'd0, rx_data};

    always_comb begin
        state_d     = state_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        error_d     = error_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        chk_d       = chk_q;
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        idle_d      = '0;
        in_frame    = (state_q == COUNT) || (state_q == DATA) || (state_q == CHECK);

        case (state_q)
            IDLE, RUN, ERR: begin
                if (accept && is_sync) begin
                    state_d     = COUNT;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                end
            end
            COUNT: begin
                if (accept) begin
                    if (rx_data == 8'd0 || n_ext > DEPTH) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d    = DATA;
                        rem_d      = rx_data;
                        chk_d      = rx_data;
                        idx_d      = '0;
                        byte_cnt_d = 2'd0;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    chk_d = chk_q ^ rx_data;
                    if (byte_cnt_q == 2'd2) begin
                        we_d       = 1'b1;
                        addr_d     = idx_q;
                        wdata_d    = INSTR_W'({asm_q, rx_data});
                        idx_d      = idx_q + 1'b1;
                        rem_d      = rem_q - 8'd1;
                        byte_cnt_d = 2'd0;
                        if (rem_q == 8'd1) begin
                            state_d = CHECK;
                        end
                    end else begin
                        asm_d      = {asm_q[7:0], rx_data};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    if (rx_data == chk_q) begin
                        state_d     = RUN;
                        cpu_reset_d = 1'b0;
                        done_d      = 1'b1;
                        error_d     = 1'b0;
                    end else begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled frame is abandoned after TIMEOUT byte-less cycles.
        if (in_frame && !accept) begin
            if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                state_d     = ERR;
                error_d     = 1'b1;
                cpu_reset_d = 1'b1;
                done_d      = 1'b0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= IDLE;
            rx_ready_q  <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            idx_q       <= '0;
            rem_q       <= '0;
            chk_q       <= '0;
            byte_cnt_q  <= '0;
            asm_q       <= '0;
            idle_q      <= '0;
        end else begin
            state_q     <= state_d;
            rx_ready_q  <= 1'b1;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            chk_q       <= chk_d;
            byte_cnt_q  <= byte_cnt_d;
            asm_q       <= asm_d;
            idle_q      <= idle_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign error      = error_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frame loading, checksum/count/timeout errors,
// reload from RUN, rx_valid gaps and mid-frame reset.
module tb_program_loader;

  localparam int TIMEOUT = 1000;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [23:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  program_loader #(
    .ADDR_W(8), .INSTR_W(24), .SYNC_BYTE(8'hA5), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done),
    .error(error), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (imem_we) got_q.push_back({imem_addr, imem_wdata});
  end

  // driver tasks
  task automatic idle_cycle();
    rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame1();
    logic [7:0] f [9];
    f = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h75};
    for (int i = 0; i < 9; i++) send_byte(f[i]);
  endtask

  task automatic compare_writes(input string name);
    idle_cycle();
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL %s write count: got %0d expected %0d", name, got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [31:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL %s write: got addr=%h data=%h expected addr=%h data=%h",
                 name, g[31:24], g[23:0], e[31:24], e[23:0]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error, state_dbg}
        !== {1'b1, 1'b0, 8'h00, 24'h000000, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL reset values: got rdy=%b we=%b addr=%h data=%h cr=%b dn=%b er=%b st=%0d expected 1 0 00 000000 1 0 0 0",
               rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error, state_dbg);
    end
    reset = 1'b0;
    got_q.delete();
  endtask

  task automatic test_good_frame();
    logic [7:0] f [9];
    f = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h75};
    for (int i = 0; i < 8; i++) send_byte(f[i]);
    total++;
    if (cpu_reset !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL good_frame pre-chk: got cr=%b dn=%b expected cr=1 dn=0", cpu_reset, done);
    end
    send_byte(f[8]);
    total++;
    if (cpu_reset !== 1'b0 || done !== 1'b1 || error !== 1'b0 || state_dbg !== 3'd4) begin
      bad++;
      $display("FAIL good_frame release: got cr=%b dn=%b er=%b st=%0d expected 0 1 0 4",
               cpu_reset, done, error, state_dbg);
    end
    exp_q.push_back({8'h00, 24'h112233});
    exp_q.push_back({8'h01, 24'h445566});
    compare_writes("good_frame");
  endtask

  task automatic test_bad_checksum();
    logic [7:0] f [9];
    f = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h74};
    send_byte(f[0]);
    total++;
    if (cpu_reset !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL bad_chk reload: got cr=%b dn=%b expected cr=1 dn=0", cpu_reset, done);
    end
    for (int i = 1; i < 9; i++) send_byte(f[i]);
    total++;
    if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL bad_chk result: got er=%b cr=%b dn=%b expected 1 1 0", error, cpu_reset, done);
    end
    exp_q.push_back({8'h00, 24'h112233});
    exp_q.push_back({8'h01, 24'h445566});
    compare_writes("bad_chk");
  endtask

  task automatic test_zero_count();
    send_byte(8'hA5);
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL zero_cnt sync clears error: got %b expected 0", error);
    end
    send_byte(8'h00);
    total++;
    if (error !== 1'b1 || state_dbg !== 3'd5 || cpu_reset !== 1'b1) begin
      bad++;
      $display("FAIL zero_cnt err: got er=%b st=%0d cr=%b expected 1 5 1", error, state_dbg, cpu_reset);
    end
    compare_writes("zero_cnt");
    send_frame1();
    total++;
    if (error !== 1'b0 || done !== 1'b1 || cpu_reset !== 1'b0) begin
      bad++;
      $display("FAIL zero_cnt recover: got er=%b dn=%b cr=%b expected 0 1 0", error, done, cpu_reset);
    end
    exp_q.push_back({8'h00, 24'h112233});
    exp_q.push_back({8'h01, 24'h445566});
    compare_writes("zero_cnt_recover");
  endtask

  task automatic test_timeout();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'hAB);
    for (int i = 0; i < TIMEOUT - 1; i++) idle_cycle();
    total++;
    if (error !== 1'b0 || state_dbg !== 3'd2) begin
      bad++;
      $display("FAIL timeout early: got er=%b st=%0d expected 0 2", error, state_dbg);
    end
    idle_cycle();
    total++;
    if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL timeout fire: got er=%b cr=%b dn=%b expected 1 1 0", error, cpu_reset, done);
    end
    compare_writes("timeout");
  endtask

  task automatic test_sync_payload();
    send_frame1();
    exp_q.push_back({8'h00, 24'h112233});
    exp_q.push_back({8'h01, 24'h445566});
    compare_writes("sync_payload_setup");
    send_byte(8'hA5);
    total++;
    if (cpu_reset !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL sync_payload reload: got cr=%b dn=%b expected 1 0", cpu_reset, done);
    end
    send_byte(8'h01);
    send_byte(8'hA5);
    send_byte(8'hA5);
    send_byte(8'hA5);
    total++;
    if (imem_we !== 1'b1 || imem_addr !== 8'h00 || imem_wdata !== 24'hA5A5A5) begin
      bad++;
      $display("FAIL sync_payload write: got we=%b addr=%h data=%h expected 1 00 a5a5a5",
               imem_we, imem_addr, imem_wdata);
    end
    send_byte(8'hA4);
    total++;
    if (cpu_reset !== 1'b0 || done !== 1'b1 || imem_we !== 1'b0 || imem_wdata !== 24'hA5A5A5) begin
      bad++;
      $display("FAIL sync_payload release: got cr=%b dn=%b we=%b data=%h expected 0 1 0 a5a5a5",
               cpu_reset, done, imem_we, imem_wdata);
    end
    exp_q.push_back({8'h00, 24'hA5A5A5});
    compare_writes("sync_payload");
  endtask

  task automatic test_gaps_and_reset();
    logic [7:0] f [4];
    f = '{8'hA5, 8'h02, 8'h11, 8'h22};
    for (int i = 0; i < 4; i++) begin
      send_byte(f[i]);
      idle_cycle();
    end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error, state_dbg}
        !== {1'b1, 1'b0, 8'h00, 24'h000000, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL midframe reset: got rdy=%b we=%b addr=%h data=%h cr=%b dn=%b er=%b st=%0d expected 1 0 00 000000 1 0 0 0",
               rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error, state_dbg);
    end
    reset = 1'b0;
    compare_writes("midframe_reset");
    // full frame again, with a gap between every byte
    f = '{8'hA5, 8'h02, 8'h11, 8'h22};
    for (int i = 0; i < 4; i++) begin
      send_byte(f[i]);
      idle_cycle();
    end
    send_byte(8'h33); idle_cycle();
    send_byte(8'h44); idle_cycle();
    send_byte(8'h55); idle_cycle();
    send_byte(8'h66); idle_cycle();
    total++;
    if (cpu_reset !== 1'b1 || state_dbg !== 3'd3) begin
      bad++;
      $display("FAIL gaps pre-chk: got cr=%b st=%0d expected 1 3", cpu_reset, state_dbg);
    end
    send_byte(8'h75);
    total++;
    if (cpu_reset !== 1'b0 || done !== 1'b1 || error !== 1'b0) begin
      bad++;
      $display("FAIL gaps release: got cr=%b dn=%b er=%b expected 0 1 0", cpu_reset, done, error);
    end
    exp_q.push_back({8'h00, 24'h112233});
    exp_q.push_back({8'h01, 24'h445566});
    compare_writes("gaps");
  endtask

  initial begin
    rx_data = 8'h00;
    rx_valid = 1'b0;
    reset = 1'b1;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_zero_count();
    test_timeout();
    test_sync_payload();
    test_gaps_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
